// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_rs,
    input  logic [WIDTH-1:0] req0_rt,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic [WIDTH-1:0] req1_rs,
    input  logic [WIDTH-1:0] req1_rt,
    input  logic [SEL_W-1:0] req1_sel,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [WIDTH-1:0] alu_rs,
    output logic [WIDTH-1:0] alu_rt,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_rd,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             pri_q;
    logic             owner_q;
    logic             busy_q;
    logic [1:0]       resp_valid_q;
    logic [WIDTH-1:0] alu_rs_q;
    logic [WIDTH-1:0] alu_rt_q;
    logic [SEL_W-1:0] alu_sel_q;
    logic [WIDTH-1:0] resp_data_q;
    logic [CNT_W-1:0] op_count_q;
    logic [CNT_W-1:0] op_count_d;

    logic [1:0]       grant;
    logic             win;
    logic [WIDTH-1:0] win_rs;
    logic [WIDTH-1:0] win_rt;
    logic [SEL_W-1:0] win_sel;

    // Grant only exists in IDLE; pri_q breaks a tie between two valid requesters.
    always_comb begin
        grant = 2'b00;
        if (state_q == IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = pri_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign win        = grant[1];
    assign win_rs     = win ? req1_rs  : req0_rs;
    assign win_rt     = win ? req1_rt  : req0_rt;
    assign win_sel    = win ? req1_sel : req0_sel;
    assign op_count_d = op_count_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pri_q        <= 1'b0;
            owner_q      <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 2'b00;
            alu_rs_q     <= '0;
            alu_rt_q     <= '0;
            alu_sel_q    <= '0;
            resp_data_q  <= '0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant != 2'b00) begin
                        alu_rs_q  <= win_rs;
                        alu_rt_q  <= win_rt;
                        alu_sel_q <= win_sel;
                        owner_q   <= win;
                        busy_q    <= 1'b1;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    // alu_rd is only sampled here, after a full cycle of settling.
                    resp_data_q  <= alu_rd;
                    resp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready[owner_q]) begin
                        pri_q        <= ~owner_q;
                        op_count_q   <= op_count_d;
                        resp_valid_q <= 2'b00;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 2'b00;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = grant;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign alu_rs     = alu_rs_q;
    assign alu_rt     = alu_rt_q;
    assign alu_sel    = alu_sel_q;
    assign busy       = busy_q;
    assign op_count   = op_count_q;

endmodule
